// File: rtl/can_wb_multi_bridge.sv
// Wishbone slave fanning one port out to NCH CAN controller register ports, with local IRQ pending/mask/status.
// Optional sticky edge-latched IRQ pending: define CAN_WB_IRQ_LATCH_EN.
module can_wb_multi_bridge #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NCH-1:0]      ch_wr_en,
    output logic [NCH-1:0]      ch_rd_en,
    output logic [REG_AW-1:0]   ch_addr,
    output logic [31:0]         ch_wr_data,
    output logic [3:0]          ch_wr_strb,
    input  logic [NCH*32-1:0]   ch_rd_data,
    input  logic [NCH-1:0]      ch_irq_i,
    output logic                irq_o
);
    localparam int unsigned CW = 3;
    localparam int unsigned LW = 3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t             state;
    logic               we_q;
    logic [CW-1:0]      chan_q;
    logic [LW-1:0]      lat_cnt;
    logic [NCH-1:0]     irq_mask;
    logic [NCH-1:0]     irq_pend;
    logic               bad_sticky;

    logic               is_local, is_bad, loc_wr;
    logic [CW-1:0]      chan;
    logic [REG_AW-1:0]  idx;
    logic [8:0]         loc_off;
    logic [31:0]        loc_rd, rd_slice;
    logic               unused_bits;

    // Address decode, only meaningful while IDLE samples a new request
    always_comb begin
        is_local = wbs_adr_i[11];
        chan     = wbs_adr_i[REG_AW+4:REG_AW+2];
        idx      = wbs_adr_i[REG_AW+1:2];
        loc_off  = wbs_adr_i[10:2];
        is_bad   = !is_local && (32'(chan) >= NCH);
        loc_wr   = (state == IDLE) && wbs_cyc_i && wbs_stb_i && is_local && wbs_we_i;
    end

    assign unused_bits = ^{wbs_adr_i[31:12], wbs_adr_i[1:0]};

    always_comb begin
        loc_rd = '0;
        case (loc_off)
            9'd0:    loc_rd[NCH-1:0] = irq_pend;
            9'd1:    loc_rd[NCH-1:0] = irq_mask;
            9'd2:    loc_rd[0]       = bad_sticky;
            default: loc_rd          = '0;
        endcase
    end

    always_comb begin
        rd_slice = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (chan_q == CW'(k)) rd_slice = ch_rd_data[32*k +: 32];
        end
    end

`ifdef CAN_WB_IRQ_LATCH_EN
    logic [NCH-1:0] irq_prev, pend_clr;

    assign pend_clr = (loc_wr && loc_off == 9'd0 && wbs_sel_i[0]) ? wbs_dat_i[NCH-1:0] : '0;

    // A rising edge on the same cycle as a clear keeps the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev <= '0;
            irq_pend <= '0;
        end else begin
            irq_prev <= ch_irq_i;
            irq_pend <= (irq_pend & ~pend_clr) | (ch_irq_i & ~irq_prev);
        end
    end
`else
    assign irq_pend = ch_irq_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            chan_q     <= '0;
            lat_cnt    <= '0;
            irq_mask   <= '0;
            bad_sticky <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            ch_wr_en   <= '0;
            ch_rd_en   <= '0;
            ch_addr    <= '0;
            ch_wr_data <= '0;
            ch_wr_strb <= '0;
            irq_o      <= 1'b0;
        end else begin
            ch_wr_en  <= '0;
            ch_rd_en  <= '0;
            wbs_ack_o <= 1'b0;
            irq_o     <= |(irq_pend & irq_mask);
            if (loc_wr && loc_off == 9'd1 && wbs_sel_i[0]) irq_mask <= wbs_dat_i[NCH-1:0];
            if (loc_wr && loc_off == 9'd2 && wbs_sel_i[0] && wbs_dat_i[0]) bad_sticky <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        we_q       <= wbs_we_i;
                        chan_q     <= chan;
                        ch_addr    <= idx;
                        ch_wr_data <= wbs_dat_i;
                        ch_wr_strb <= wbs_sel_i;
                        if (is_local || is_bad) begin
                            state     <= ACK;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= (is_local && !wbs_we_i) ? loc_rd : '0;
                            if (is_bad) bad_sticky <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            if (wbs_we_i) ch_wr_en <= NCH'(1) << chan;
                            else          ch_rd_en <= NCH'(1) << chan;
                        end
                    end
                end
                ISSUE: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (we_q) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= '0;
                    end else if (RD_LAT == 0) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= rd_slice;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (lat_cnt == LW'(RD_LAT - 1)) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= rd_slice;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wbs_dat_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_can_wb_multi_bridge.sv
// Bench for can_wb_multi_bridge: two instances (read latency 1 and 4) share one WB master and are
// compared against a transaction-level model of the register map and a fake channel register file.
module tb_can_wb_multi_bridge;
    localparam int unsigned NCH = 2, REG_AW = 5, LAT_A = 1, LAT_B = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic cyc = 0, stb = 0, we = 0;
    logic [3:0] sel = 0;
    logic [31:0] adr = 0, dat = 0;
    logic [63:0] rd_a = 0, rd_b = 0;
    logic [1:0] irq = 0;

    logic ack_a, ack_b, irq_a, irq_b;
    logic [31:0] do_a, do_b, wd_a, wd_b;
    logic [1:0] wen_a, ren_a, wen_b, ren_b;
    logic [4:0] addr_a, addr_b;
    logic [3:0] st_a, st_b;

    can_wb_multi_bridge #(.NCH(NCH), .REG_AW(REG_AW), .RD_LAT(LAT_A)) u_a (
        .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_a), .wbs_dat_o(do_a), .ch_wr_en(wen_a),
        .ch_rd_en(ren_a), .ch_addr(addr_a), .ch_wr_data(wd_a), .ch_wr_strb(st_a), .ch_rd_data(rd_a),
        .ch_irq_i(irq), .irq_o(irq_a));

    can_wb_multi_bridge #(.NCH(NCH), .REG_AW(REG_AW), .RD_LAT(LAT_B)) u_b (
        .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_b), .wbs_dat_o(do_b), .ch_wr_en(wen_b),
        .ch_rd_en(ren_b), .ch_addr(addr_b), .ch_wr_data(wd_b), .ch_wr_strb(st_b), .ch_rd_data(rd_b),
        .ch_irq_i(irq), .irq_o(irq_b));

    int errs = 0, checks = 0;
    logic [31:0] tab [NCH][32];
    logic [1:0] m_mask = 0, m_pend = 0;
    logic m_status = 0;

    // Fake channel cores: read data is valid only in the cycle RD_LAT after the read strobe, junk otherwise
    int cnt_a = 0, cnt_b = 0, ch_a = 0, ch_b = 0, ix_a = 0, ix_b = 0;
    always @(negedge clk) begin
        rd_a = {$urandom, $urandom};
        rd_b = {$urandom, $urandom};
        if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) rd_a[32*ch_a +: 32] = tab[ch_a][ix_a];
        end
        if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) rd_b[32*ch_b +: 32] = tab[ch_b][ix_b];
        end
        if (ren_a != 0) begin cnt_a = LAT_A; ch_a = ren_a[1] ? 1 : 0; ix_a = int'(addr_a); end
        if (ren_b != 0) begin cnt_b = LAT_B; ch_b = ren_b[1] ? 1 : 0; ix_b = int'(addr_b); end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] outs_a();
        return 96'({ack_a, do_a, wen_a, ren_a, addr_a, wd_a, st_a, irq_a});
    endfunction
    function automatic logic [95:0] outs_b();
        return 96'({ack_b, do_b, wen_b, ren_b, addr_b, wd_b, st_b, irq_b});
    endfunction

    // One WB transaction; cut>=0 drops cyc (or asserts reset) after sampling cycle cut
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int cut, input bit cut_rst);
        bit loc, bad, ea, eb;
        int ch, ix, la, lb, off;
        int an_a = -1, an_b = -1, nack_a = 0, nack_b = 0, sbad_a = 0, sbad_b = 0;
        logic [31:0] exp_d, got_a = 0, got_b = 0;
        logic [1:0] ew, er, live;
        loc = a[11]; ch = int'(a[9:7]); ix = int'(a[6:2]); off = int'(a[10:2]);
        bad = !loc && ch >= int'(NCH);
        la = (loc || bad) ? 1 : (w ? 2 : 2 + LAT_A);
        lb = (loc || bad) ? 1 : (w ? 2 : 2 + LAT_B);
`ifdef CAN_WB_IRQ_LATCH_EN
        live = m_pend;
`else
        live = irq;
`endif
        exp_d = 0;
        if (!w && loc) exp_d = (off == 0) ? 32'(live) : (off == 1) ? 32'(m_mask) : (off == 2) ? 32'(m_status) : 0;
        else if (!w && !bad) exp_d = tab[ch][ix];
        if (bad) m_status = 1;
        if (loc && w && s[0]) begin
            if (off == 1) m_mask = d[1:0];
            if (off == 2 && d[0]) m_status = 0;
`ifdef CAN_WB_IRQ_LATCH_EN
            if (off == 0) m_pend = m_pend & ~d[1:0];
`endif
        end
        ew = (!loc && !bad && w) ? 2'(1 << ch) : 2'b00;
        er = (!loc && !bad && !w) ? 2'(1 << ch) : 2'b00;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ack_a) begin nack_a++; an_a = n; got_a = do_a; end else if (do_a != 0) sbad_a++;
            if (ack_b) begin nack_b++; an_b = n; got_b = do_b; end else if (do_b != 0) sbad_b++;
            if (n == 0) begin
                if (wen_a != ew || ren_a != er) sbad_a++;
                if (wen_b != ew || ren_b != er) sbad_b++;
                if (ew != 0 || er != 0) begin
                    if (int'(addr_a) != ix || int'(addr_b) != ix) begin sbad_a++; sbad_b++; end
                end
                if (ew != 0 && (wd_a != d || st_a != s)) sbad_a++;
                if (ew != 0 && (wd_b != d || st_b != s)) sbad_b++;
                stb = 0;
            end else begin
                if (wen_a != 0 || ren_a != 0) sbad_a++;
                if (wen_b != 0 || ren_b != 0) sbad_b++;
            end
            if (n == cut) begin
                if (cut_rst) begin
                    rst_n = 0;
                    #1;
                    chk("rst_mid_a", outs_a(), 96'd0);
                    chk("rst_mid_b", outs_b(), 96'd0);
                end else cyc = 0;
            end
        end
        cyc = 0;
        if (cut_rst) begin rst_n = 1; m_mask = 0; m_status = 0; m_pend = 0; end
        ea = !(cut >= 0 && cut < la - 1);
        eb = !(cut >= 0 && cut < lb - 1);
        chk("ack_count_a", nack_a, ea ? 1 : 0);
        chk("ack_count_b", nack_b, eb ? 1 : 0);
        if (ea) chk("ack_time_a", an_a, la - 1);
        if (eb) chk("ack_time_b", an_b, lb - 1);
        if (ea && !w) chk("rdata_a", got_a, exp_d);
        if (eb && !w) chk("rdata_b", got_b, exp_d);
        chk("strobes_a", sbad_a, 0);
        chk("strobes_b", sbad_b, 0);
`ifdef CAN_WB_IRQ_LATCH_EN
        live = m_pend;
`else
        live = irq;
`endif
        chk("irq_a", irq_a, |(live & m_mask));
        chk("irq_b", irq_b, |(live & m_mask));
    endtask

    initial begin
        logic [31:0] a;
        int kind, r;
        for (int c = 0; c < int'(NCH); c++)
            for (int i = 0; i < 32; i++) tab[c][i] = $urandom;
        tab[1][1] = 32'hCAFE_0001;
        repeat (2) @(negedge clk);
        chk("reset_a", outs_a(), 96'd0);
        chk("reset_b", outs_b(), 96'd0);
        rst_n = 1;

        xfer(1, 32'h0000_0008, 32'hA5A5_1234, 4'hF, -1, 0);
        xfer(0, 32'h0000_0084, 0, 4'hF, -1, 0);
        xfer(0, 32'h0000_0100, 0, 4'hF, -1, 0);
        xfer(0, 32'h0000_0808, 0, 4'hF, -1, 0);
        xfer(1, 32'h0000_0808, 32'h1, 4'hF, -1, 0);
        xfer(0, 32'h0000_0808, 0, 4'hF, -1, 0);

        xfer(1, 32'h0000_0804, 32'h2, 4'h1, -1, 0);
`ifdef CAN_WB_IRQ_LATCH_EN
        @(negedge clk); irq[1] = 1; @(negedge clk); irq[1] = 0; m_pend[1] = 1;
        xfer(0, 32'h0000_0800, 0, 4'hF, -1, 0);
        xfer(1, 32'h0000_0800, 32'h2, 4'h1, -1, 0);
        xfer(1, 32'h0000_0804, 32'h0, 4'h1, -1, 0);
        @(negedge clk); irq[1] = 1; @(negedge clk); irq[1] = 0; m_pend[1] = 1;
        xfer(0, 32'h0000_0800, 0, 4'hF, -1, 0);
        xfer(1, 32'h0000_0800, 32'h3, 4'h1, -1, 0);
`else
        irq = 2'b10;
        xfer(0, 32'h0000_0800, 0, 4'hF, -1, 0);
        irq = 2'b00;
        xfer(0, 32'h0000_0800, 0, 4'hF, -1, 0);
        xfer(1, 32'h0000_0804, 32'h0, 4'h1, -1, 0);
        irq = 2'b10;
        xfer(0, 32'h0000_0800, 0, 4'hF, -1, 0);
        irq = 2'b00;
`endif

        xfer(0, 32'h0000_0084, 0, 4'hF, 2, 0);
        xfer(1, 32'h0000_0094, 32'h1357_9BDF, 4'h6, -1, 0);
        xfer(1, 32'h0000_0804, 32'h3, 4'h1, -1, 0);
        xfer(0, 32'h0000_0084, 0, 4'hF, 1, 1);
        xfer(0, 32'h0000_0804, 0, 4'hF, -1, 0);

        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                a[11] = 1'b1;
                a[10:2] = 9'($urandom_range(0, 4));
            end else begin
                a[11] = 1'b0;
                r = $urandom_range(0, 9);
                a[9:7] = (r < 8) ? 3'(r % 2) : 3'($urandom_range(2, 7));
            end
`ifndef CAN_WB_IRQ_LATCH_EN
            irq = 2'($urandom);
`endif
            xfer(1'($urandom), a, $urandom, 4'($urandom), -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
